// File: rtl/dtcm_ram_ctrl_pkg.sv
// Shared widths, FSM state encoding and small helpers for the DTCM RAM controller.
package dtcm_ram_ctrl_pkg;

    localparam int DTCM_XLEN    = 32;
    localparam int DTCM_PC_SIZE = 32;
    localparam int DTCM_AW      = 14;
    // Wait-state counter width; covers WAIT_CYCLES 0..15.
    localparam int WAIT_W       = 4;

    typedef enum logic [1:0] {
        DTCM_IDLE  = 2'b00,
        DTCM_WAIT  = 2'b01,
        DTCM_ISSUE = 2'b10,
        DTCM_RESP  = 2'b11
    } dtcm_state_e;

    // Counter value loaded at accept: the WAIT state is left once it reaches zero.
    function automatic logic [WAIT_W-1:0] wait_load(input int unsigned wait_cycles);
        if (wait_cycles == 0) begin
            return '0;
        end
        return WAIT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/gnrl_dfflr_ar.sv
// Load-enabled register with asynchronous active-high reset; every flop of the DTCM controller is built from it.
module gnrl_dfflr_ar #(
    parameter int            DW      = 1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/dtcm_ram_ctrl.sv
// Data-RAM controller between the LSU and a single-port synchronous SRAM (1-cycle read latency),
// with optional wait states, out-of-range flagging and a held read-data word.
module dtcm_ram_ctrl
    import dtcm_ram_ctrl_pkg::*;
#(
    parameter int XLEN        = DTCM_XLEN,
    parameter int PC_SIZE     = DTCM_PC_SIZE,
    parameter int AW          = DTCM_AW,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               lsu_ram_valid,
    input  logic               lsu_ram_rd,
    input  logic               lsu_ram_wr,
    input  logic [PC_SIZE-1:0] lsu_ram_addr,
    input  logic [XLEN-1:0]    lsu_ram_wdata,
    output logic [XLEN-1:0]    ram_lsu_rdata,
    output logic               ram_lsu_ready,
    output logic               ram_lsu_err,
    output logic               dtcm_busy,

    output logic               sram_ce,
    output logic               sram_we,
    output logic [AW-1:0]      sram_addr,
    output logic [XLEN-1:0]    sram_wdata,
    input  logic [XLEN-1:0]    sram_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = wait_load(WAIT_CYCLES);

    typedef struct packed {
        logic            op_wr;
        logic            range_err;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] wdata;
    } cmd_t;

    dtcm_state_e       state_q;
    dtcm_state_e       state_d;
    logic [1:0]        state_bits_q;
    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;
    logic              cnt_en;
    cmd_t              cmd_q;
    cmd_t              cmd_d;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   rdata_d;
    logic              accept;
    logic              range_err_in;
    logic              rd_resp;

    generate
        if (PC_SIZE > AW) begin : g_range
            assign range_err_in = |lsu_ram_addr[PC_SIZE-1:AW];
        end else begin : g_no_range
            assign range_err_in = 1'b0;
        end
    endgenerate

    assign accept = (state_q == DTCM_IDLE) & lsu_ram_valid & (lsu_ram_rd | lsu_ram_wr);

    // Write wins when both rd and wr are raised together.
    assign cmd_d.op_wr     = lsu_ram_wr;
    assign cmd_d.range_err = range_err_in;
    assign cmd_d.addr      = lsu_ram_addr[AW-1:0];
    assign cmd_d.wdata     = lsu_ram_wdata;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_en  = 1'b0;
        unique case (state_q)
            DTCM_IDLE: begin
                if (accept) begin
                    cnt_d  = WAIT_INIT;
                    cnt_en = 1'b1;
                    if (range_err_in) begin
                        state_d = DTCM_RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = DTCM_WAIT;
                    end else begin
                        state_d = DTCM_ISSUE;
                    end
                end
            end
            DTCM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DTCM_ISSUE;
                end else begin
                    cnt_d  = cnt_q - WAIT_W'(1);
                    cnt_en = 1'b1;
                end
            end
            DTCM_ISSUE: state_d = DTCM_RESP;
            DTCM_RESP:  state_d = DTCM_IDLE;
            default:    state_d = DTCM_IDLE;
        endcase
    end

    gnrl_dfflr_ar #(
        .DW      (2),
        .RST_VAL (DTCM_IDLE)
    ) u_state_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (1'b1),
        .d_i  (state_d),
        .q_o  (state_bits_q)
    );

    assign state_q = dtcm_state_e'(state_bits_q);

    gnrl_dfflr_ar #(
        .DW (WAIT_W)
    ) u_cnt_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (cnt_en),
        .d_i  (cnt_d),
        .q_o  (cnt_q)
    );

    gnrl_dfflr_ar #(
        .DW ($bits(cmd_t))
    ) u_cmd_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (accept),
        .d_i  (cmd_d),
        .q_o  (cmd_q)
    );

    // Read response: SRAM data is bypassed straight out and captured so it stays
    // stable through LSU writeback and a following store-merge write.
    assign rd_resp = (state_q == DTCM_RESP) & ~cmd_q.op_wr;
    assign rdata_d = cmd_q.range_err ? '0 : sram_rdata;

    gnrl_dfflr_ar #(
        .DW (XLEN)
    ) u_rdata_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (rd_resp),
        .d_i  (rdata_d),
        .q_o  (rdata_q)
    );

    assign ram_lsu_rdata = rd_resp ? rdata_d : rdata_q;
    assign ram_lsu_ready = (state_q == DTCM_RESP);
    assign ram_lsu_err   = ram_lsu_ready & cmd_q.range_err;
    assign dtcm_busy     = (state_q != DTCM_IDLE);

    // Out-of-range commands skip ISSUE, so the SRAM is never enabled for them.
    assign sram_ce    = (state_q == DTCM_ISSUE);
    assign sram_we    = sram_ce & cmd_q.op_wr;
    assign sram_addr  = cmd_q.addr;
    assign sram_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_dtcm_ram_ctrl.sv
// Self-checking bench: three controllers (0, 3 and 2 wait states) each with its own SRAM model,
// checked cycle by cycle against a timing/memory reference derived from the access rules.
module tb_dtcm_ram_ctrl;

    localparam int NDUT  = 3;
    localparam int XW    = 32;
    localparam int PW    = 32;
    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    logic          clk;
    logic          rst    [NDUT];
    logic          valid  [NDUT];
    logic          rd     [NDUT];
    logic          wr     [NDUT];
    logic [PW-1:0] addr   [NDUT];
    logic [XW-1:0] wdata  [NDUT];
    logic [XW-1:0] rdata  [NDUT];
    logic          ready  [NDUT];
    logic          err    [NDUT];
    logic          busy   [NDUT];
    logic          ce     [NDUT];
    logic          we     [NDUT];
    logic [AW-1:0] saddr  [NDUT];
    logic [XW-1:0] swdata [NDUT];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: expected memory contents per controller and the expected held read word.
    logic [XW-1:0] ref_mem [int];
    logic [XW-1:0] hold    [NDUT];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [XW-1:0] mem [DEPTH];
        logic [XW-1:0] sram_rdata_m;

        dtcm_ram_ctrl #(
            .XLEN        (XW),
            .PC_SIZE     (PW),
            .AW          (AW),
            .WAIT_CYCLES (wait_of(g))
        ) u_dut (
            .clk           (clk),
            .rst           (rst[g]),
            .lsu_ram_valid (valid[g]),
            .lsu_ram_rd    (rd[g]),
            .lsu_ram_wr    (wr[g]),
            .lsu_ram_addr  (addr[g]),
            .lsu_ram_wdata (wdata[g]),
            .ram_lsu_rdata (rdata[g]),
            .ram_lsu_ready (ready[g]),
            .ram_lsu_err   (err[g]),
            .dtcm_busy     (busy[g]),
            .sram_ce       (ce[g]),
            .sram_we       (we[g]),
            .sram_addr     (saddr[g]),
            .sram_wdata    (swdata[g]),
            .sram_rdata    (sram_rdata_m)
        );

        // SRAM model: 1-cycle read latency; read port carries junk when no read was issued.
        always @(posedge clk) begin
            if (ce[g] && we[g]) mem[saddr[g]] <= swdata[g];
            if (ce[g] && !we[g]) sram_rdata_m <= mem[saddr[g]];
            else sram_rdata_m <= $urandom;
        end
    end

    function automatic int key(input int d, input logic [PW-1:0] a);
        return d * DEPTH + int'(a[AW-1:0]);
    endfunction

    // One LSU access: drive at the current negedge (cycle T), then check every cycle through ready+1.
    task automatic access(input int d, input bit is_wr, input logic [PW-1:0] a, input logic [XW-1:0] wd,
                          input bit both, input bit hold_valid, output int rdy_cyc);
        int            w;
        int            exp_r;
        int            exp_ce;
        bit            oob;
        logic [XW-1:0] exp_rd;
        w      = wait_of(d);
        oob    = (a[PW-1:AW] != '0);
        exp_r  = oob ? 1 : 2 + w;
        exp_ce = oob ? -1 : 1 + w;
        exp_rd = '0;
        if (!is_wr && !oob && ref_mem.exists(key(d, a))) exp_rd = ref_mem[key(d, a)];
        rdy_cyc = -1;
        total++;
        if (busy[d] !== 1'b0) begin
            bad++;
            $display("FAIL idle_before dut%0d: busy=%b want 0", d, busy[d]);
        end
        valid[d] = 1'b1;
        rd[d]    = !is_wr || both;
        wr[d]    = is_wr;
        addr[d]  = a;
        wdata[d] = wd;
        for (int k = 1; k <= exp_r + 1; k++) begin
            @(negedge clk);
            total++;
            if (busy[d] !== (k <= exp_r)) begin
                bad++;
                $display("FAIL busy dut%0d k=%0d: got %b want %b", d, k, busy[d], k <= exp_r);
            end
            total++;
            if (ce[d] !== (k == exp_ce)) begin
                bad++;
                $display("FAIL sram_ce dut%0d k=%0d: got %b want %b", d, k, ce[d], k == exp_ce);
            end
            total++;
            if (ready[d] !== (k == exp_r)) begin
                bad++;
                $display("FAIL ready dut%0d k=%0d: got %b want %b", d, k, ready[d], k == exp_r);
            end
            if (k == exp_ce) begin
                total++;
                if ({we[d], saddr[d]} !== {is_wr, a[AW-1:0]}) begin
                    bad++;
                    $display("FAIL sram_cmd dut%0d: we/addr got %b/%h want %b/%h", d, we[d], saddr[d], is_wr, a[AW-1:0]);
                end
                if (is_wr) begin
                    total++;
                    if (swdata[d] !== wd) begin
                        bad++;
                        $display("FAIL sram_wdata dut%0d: got %h want %h", d, swdata[d], wd);
                    end
                end
            end
            if (k == exp_r) begin
                rdy_cyc = cyc;
                total++;
                if (err[d] !== oob) begin
                    bad++;
                    $display("FAIL err dut%0d addr=%h: got %b want %b", d, a, err[d], oob);
                end
                if (!is_wr) hold[d] = exp_rd;
                else if (!oob) ref_mem[key(d, a)] = wd;
            end
            total++;
            if (rdata[d] !== hold[d]) begin
                bad++;
                $display("FAIL rdata dut%0d k=%0d addr=%h: got %h want %h", d, k, a, rdata[d], hold[d]);
            end
            if (k == 1 && !hold_valid) begin
                valid[d] = 1'b0;
                rd[d]    = 1'($urandom);
                wr[d]    = 1'($urandom);
                addr[d]  = $urandom;
                wdata[d] = $urandom;
            end
        end
        valid[d] = 1'b0;
        rd[d]    = 1'b0;
        wr[d]    = 1'b0;
    endtask

    task automatic idle_check(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            total++;
            if ({ready[d], ce[d], busy[d]} !== 3'b000 || rdata[d] !== hold[d]) begin
                bad++;
                $display("FAIL idle dut%0d: ready/ce/busy=%b%b%b rdata=%h want 000 %h",
                         d, ready[d], ce[d], busy[d], rdata[d], hold[d]);
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if ({ready[d], err[d], ce[d], we[d], busy[d]} !== 5'b0 || rdata[d] !== '0) begin
                bad++;
                $display("FAIL reset dut%0d: ready/err/ce/we/busy=%b%b%b%b%b rdata=%h want 00000 0",
                         d, ready[d], err[d], ce[d], we[d], busy[d], rdata[d]);
            end
            hold[d] = '0;
        end
    endtask

    task automatic test_no_op(input int d);
        valid[d] = 1'b1;
        rd[d]    = 1'b0;
        wr[d]    = 1'b0;
        addr[d]  = 32'h10;
        idle_check(d, 3);
        valid[d] = 1'b0;
    endtask

    task automatic test_basic_read(input int d);
        int rc;
        access(d, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, rc);
        access(d, 1'b0, 32'h10, '0, 1'b0, 1'b0, rc);
        idle_check(d, 3);
    endtask

    task automatic test_write_hold(input int d);
        int rc;
        access(d, 1'b1, 32'h30, 32'hA5A5_A5A5, 1'b0, 1'b0, rc);
        access(d, 1'b0, 32'h30, '0, 1'b0, 1'b0, rc);
        access(d, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 1'b0, rc);
        idle_check(d, 2);
        access(d, 1'b0, 32'h20, '0, 1'b0, 1'b0, rc);
    endtask

    task automatic test_range_err(input int d);
        int rc;
        access(d, 1'b1, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, rc);
        access(d, 1'b0, 32'h0, '0, 1'b0, 1'b0, rc);
        access(d, 1'b0, 32'h4000, '0, 1'b0, 1'b0, rc);
        access(d, 1'b1, 32'h4000, 32'hFFFF_FFFF, 1'b0, 1'b0, rc);
        access(d, 1'b0, 32'h0, '0, 1'b0, 1'b0, rc);
        access(d, 1'b1, 32'h8000_0000, 32'h5555_AAAA, 1'b1, 1'b0, rc);
        access(d, 1'b0, 32'h8000_0000, '0, 1'b0, 1'b1, rc);
        access(d, 1'b0, 32'h0, '0, 1'b0, 1'b0, rc);
    endtask

    task automatic test_back_to_back(input int d);
        int r1, r2, r3;
        int gap;
        gap = 3 + wait_of(d);
        access(d, 1'b0, 32'h20, '0, 1'b0, 1'b1, r1);
        access(d, 1'b1, 32'h21, 32'hCAFE_0001, 1'b0, 1'b1, r2);
        access(d, 1'b0, 32'h21, '0, 1'b0, 1'b0, r3);
        total++;
        if (r2 - r1 != gap || r3 - r2 != gap) begin
            bad++;
            $display("FAIL b2b_spacing dut%0d: gaps %0d,%0d want %0d", d, r2 - r1, r3 - r2, gap);
        end
    endtask

    task automatic test_reset_mid(input int d, input int at_k);
        valid[d] = 1'b1;
        rd[d]    = 1'b1;
        wr[d]    = 1'b0;
        addr[d]  = 32'h10;
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clk);
            if (k == 1) valid[d] = 1'b0;
        end
        rst[d] = 1'b1;
        #1;
        total++;
        if ({ce[d], busy[d], ready[d]} !== 3'b000 || rdata[d] !== '0) begin
            bad++;
            $display("FAIL reset_mid dut%0d k=%0d: ce/busy/ready=%b%b%b rdata=%h want 000 0",
                     d, at_k, ce[d], busy[d], ready[d], rdata[d]);
        end
        hold[d] = '0;
        @(negedge clk);
        rst[d] = 1'b0;
        rd[d]  = 1'b0;
        idle_check(d, 5);
    endtask

    task automatic test_random(input int d, input int n_ops);
        logic [PW-1:0] pool [8];
        logic [PW-1:0] a;
        int            rc;
        int            sel;
        for (int i = 0; i < 8; i++) begin
            pool[i] = PW'($urandom_range(0, DEPTH - 1));
            access(d, 1'b1, pool[i], $urandom, 1'b0, 1'($urandom), rc);
        end
        for (int i = 0; i < n_ops; i++) begin
            sel = int'($urandom_range(0, 9));
            a   = pool[$urandom_range(0, 7)];
            if (sel >= 8) a[PW-1:AW] = (PW - AW)'($urandom_range(1, (1 << (PW - AW)) - 1));
            access(d, sel[0], a, $urandom, 1'($urandom), 1'($urandom), rc);
            if ($urandom_range(0, 3) == 0) idle_check(d, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d]   = 1'b1;
            valid[d] = 1'b0;
            rd[d]    = 1'b0;
            wr[d]    = 1'b0;
            addr[d]  = '0;
            wdata[d] = '0;
            hold[d]  = '0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        @(negedge clk);

        for (int d = 0; d < NDUT; d++) begin
            test_no_op(d);
            test_basic_read(d);
            test_write_hold(d);
            test_range_err(d);
            test_back_to_back(d);
            test_random(d, 40);
        end

        test_reset_mid(2, 1);
        test_basic_read(2);
        test_reset_mid(2, 3);
        test_write_hold(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtcm_ram_ctrl.md
Name: dtcm_ram_ctrl

Overview:
- Data-RAM controller directly downstream of the LSU. Consumes the LSU RAM request (valid/rd/wr/word address/wdata) and drives a single-port synchronous SRAM with 1-cycle read latency.
- Returns a one-cycle ready pulse and a read-data word that stays stable until the next read completes. The LSU relies on this held word to write back loads and to merge sub-word stores.
- Supports a configurable number of wait states and flags out-of-range addresses.

Parameters:
- XLEN, 32, data width (from mcu_defines).
- PC_SIZE, 32, width of the incoming word-address bus.
- AW, 14, SRAM word-address width; depth = 2**AW words.
- WAIT_CYCLES, 0, extra cycles inserted before each SRAM access; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- lsu_ram_valid  in  1  request valid.
- lsu_ram_rd  in  1  read request.
- lsu_ram_wr  in  1  write request; has priority if rd is also high.
- lsu_ram_addr  in  PC_SIZE  word address.
- lsu_ram_wdata  in  XLEN  full-word write data, already merged by the LSU.
- ram_lsu_rdata  out  XLEN  read data, held between reads.
- ram_lsu_ready  out  1  one-cycle completion pulse.
- ram_lsu_err  out  1  valid with ready: address out of range.
- dtcm_busy  out  1  high when the FSM is not in IDLE.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  AW  SRAM address.
- sram_wdata  out  XLEN  SRAM write data.
- sram_rdata  in  XLEN  SRAM read data; valid the cycle after sram_ce with sram_we=0.

Behaviour:
- Single clock domain. Reset is asynchronous, active-high, and affects all state flops.
- Reset values: FSM=IDLE, ram_lsu_ready=0, ram_lsu_err=0, rdata_q=0 (so ram_lsu_rdata=0), sram_ce=0, sram_we=0, dtcm_busy=0.
- FSM states: IDLE, WAIT, ISSUE, RESP.
- IDLE:
  - Accept when lsu_ram_valid & (lsu_ram_rd | lsu_ram_wr).
  - On accept, register op (wr wins over rd), addr, and wdata. Set range_err = |lsu_ram_addr[PC_SIZE-1:AW].
  - Next state: RESP if range_err; otherwise WAIT if WAIT_CYCLES>0, else ISSUE.
  - valid with neither rd nor wr: ignored, stay in IDLE.
- WAIT: down-counter loaded with WAIT_CYCLES-1 at accept. Go to ISSUE when it reaches 0.
- ISSUE: sram_ce=1, sram_we=op_wr, sram_addr=addr_q[AW-1:0], sram_wdata=wdata_q. Next state RESP.
- RESP:
  - ram_lsu_ready=1 and ram_lsu_err=range_err for exactly this cycle. Next state IDLE.
  - Read, no error: ram_lsu_rdata = sram_rdata this cycle (bypass), and rdata_q <= sram_rdata.
  - Read with error: ram_lsu_rdata = 0 and rdata_q <= 0.
  - Write, error or not: rdata_q is unchanged.
  - Write with error: no SRAM access occurs.
- Outside a read RESP cycle, ram_lsu_rdata = rdata_q. This keeps read data stable through the LSU writeback cycle and through the following store-merge write phase.
- Latency, measured from the first cycle valid is sampled high in IDLE (T):
  - normal access: ready at T+2+WAIT_CYCLES.
  - range error: ready at T+1.
- Back-to-back: a new request can be accepted in the cycle after RESP, giving a throughput of one access per 3+WAIT_CYCLES cycles.
- Command is captured at accept. Deasserting valid, or changing addr/wdata, in WAIT/ISSUE/RESP does not abort or alter the access; ready still pulses.
- dtcm_busy = (state != IDLE).
- The SRAM is never enabled outside ISSUE. At most one access is outstanding.
- Reset asserted mid-access returns the FSM to IDLE immediately. The pending access is dropped with no ready, and sram_ce falls asynchronously.

Decomposition:
- mcu_defines (shared include) gains DTCM_AW plus state encodings DTCM_IDLE=2'b00, DTCM_WAIT=2'b01, DTCM_ISSUE=2'b10, DTCM_RESP=2'b11.
- One natural sub-module: gnrl_dfflr_ar, a load-enabled register with asynchronous active-high reset. All state, command, counter, and rdata registers use it.

Test Plan:
- WAIT_CYCLES=0: pre-load word 0x10 = 0xDEADBEEF; read addr 0x10 with valid at T → sram_ce at T+1, ready=1 and rdata=0xDEADBEEF at T+2; rdata still 0xDEADBEEF at T+5.
- Write addr 0x20, wdata 0x12345678, after a prior read returned 0xA5A5A5A5 → sram_we at T+1, ready at T+2, ram_lsu_rdata stays 0xA5A5A5A5; readback of 0x20 = 0x12345678.
- WAIT_CYCLES=3: read → sram_ce only at T+4, ready only at T+5; dtcm_busy high from T+1 to T+5.
- Range error, AW=14: read addr 0x4000 → no sram_ce, ready=1 and err=1 at T+1, rdata=0. Write to 0x4000 → memory unchanged.
- Deassert valid in the cycle after accept → access completes with ready at T+2. Back-to-back read then write (LSU-style) → two ready pulses 3 cycles apart.
- Assert rst while in WAIT (WAIT_CYCLES=2) → FSM returns to IDLE, no ready pulse; next request behaves normally.
